dqs_rdlvl_ctrl: RTL and testbench
=================================

// Module: dqs_rdlvl_ctrl
// PURPOSE
// Multi-lane DQS read-leveling engine for the ECP3 DDR PHY. Sweeps the DQS buffer dynamic
// delay (and optionally delay polarity) across all byte lanes in parallel, issues a test read
// per step through the memory controller, records each lane's longest contiguous passing
// window, and finally drives every lane's DYNDELAY/DYNDELPOL to that window's centre.
// PARAMETERS
// LANES      2    number of DQS byte lanes calibrated in parallel
// DLY_W      7    width of the DQSBUFD dynamic delay code (sweep 0 .. 2**DLY_W-1)
// SETTLE     8    sclk cycles waited after each delay change before the read request
// MIN_WIN    4    minimum window length; shorter (or none) marks the lane failed
// POL_SWEEP  0    0: polarity fixed at 0; 1: full delay sweep at pol 0, then at pol 1
// TIMEOUT    255  max sclk cycles from rd_req rise to rd_vld before abort
// PORTS
// sclk        in   1            system clock; all logic on rising edge
// rst_n       in   1            asynchronous active-low reset
// cal_start   in   1            start request; sampled only in IDLE
// cal_busy    out  1            high from the cycle after cal_start until DONE/FAIL
// cal_done    out  1            level; high after completion (incl. timeout) until next start
// cal_timeout out  1            level; set on read timeout, cleared by next start
// lane_fail   out  LANES        per-lane failure flags, valid while cal_done=1
// rd_req      out  1            test-read request to controller
// rd_ack      in   1            controller accepts request
// rd_vld      in   1            one-cycle pulse: test-read result valid
// rd_pass     in   LANES        per-lane pattern match, qualified by rd_vld
// dyndelay    out  LANES*DLY_W  per-lane delay code to DQSBUFD DYNDELAY (lane i at [i*DLY_W +: DLY_W])
// dyndelpol   out  LANES        per-lane DYNDELPOL
// BEHAVIOUR
// - Reset: all outputs 0; FSM=IDLE; per-lane window trackers cleared.
// - FSM: IDLE -> SETDLY -> SETTLE -> REQ -> WAIT -> UPDATE -> (SETDLY | FINISH) -> DONE; any timeout -> FAIL.
//   IDLE: cal_start=1 -> clear cal_done, cal_timeout, lane_fail, trackers; dly=0, pol=0; go SETDLY.
//   SETDLY: all lanes dyndelay=dly, dyndelpol=pol (one cycle). SETTLE: count SETTLE cycles.
//   REQ: rd_req=1, held until rd_ack=1 sampled; rd_req drops the cycle after. Timeout counter starts at rd_req rise.
//   WAIT: wait rd_vld; rd_pass ignored when rd_vld=0. rd_vld while in REQ is ignored.
//   UPDATE per lane: pass -> if run open len++, else start=dly,len=1; fail -> close run.
//   Close run: if len > best_len (strictly) -> best=(start,len,pol). Ties keep the earlier window.
//   Next step: dly<max -> dly+1, SETDLY. dly==max: close all open runs (no wrap, runs never span
//   max->0 or a polarity change); if POL_SWEEP=1 and pol=0 -> pol=1, dly=0, SETDLY; else FINISH.
//   FINISH (1 cycle): per lane best_len>=MIN_WIN -> dyndelay=best_start+(best_len>>1) (floor),
//   dyndelpol=best_pol; else lane_fail=1, dyndelay=0, dyndelpol=0. Then DONE.
//   DONE: cal_busy=0, cal_done=1; outputs held; -> IDLE same cycle (cal_done stays high).
//   FAIL: rd_req=0, cal_timeout=1, lane_fail=all ones, dyndelay=0, dyndelpol=0, cal_done=1 -> IDLE.
// - Widths: best_len/run len DLY_W+1 bits (max 2**DLY_W); centre computed DLY_W+1, fits DLY_W.
// - Timeout: counter > TIMEOUT without rd_vld -> FAIL (TIMEOUT+1 cycles after rd_req rise).
// - cal_start while busy ignored. rst_n low mid-sweep: immediate return to reset values; the
//   next cal_start restarts from dly=0, pol=0 with no memory of prior sweep.
// - Steps per run = 2**DLY_W*(1+POL_SWEEP); each step >= SETTLE+3 cycles.
// TESTING
// - Lane0 pass 20..60, lane1 pass 10..30 -> cal_done=1, dyndelay {20,40}, lane_fail=0, pol 0.
// - Lane0 pass 5..9 and 50..69, lane1 pass 120..127 (open at end) -> lane0=60, lane1=124.
// - Lane1 pass 3..5 only (len 3 < MIN_WIN) -> lane_fail=2'b10, lane1 delay 0, lane0 valid.
// - Withhold rd_vld at dly=17 -> cal_timeout=1 after 256 cycles, lane_fail=2'b11, rd_req=0, busy=0.
// - rst_n pulsed low at dly=33 -> all outputs 0 asynchronously; new cal_start resweeps from 0.
// - POL_SWEEP=1: lane0 pol0 10..19, pol1 40..69 -> dyndelpol[0]=1, delay 55; equal lengths -> pol 0.

Source files
------------

// File: rtl/dqs_rdlvl_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dqs_rdlvl_ctrl
// Description : Multi-lane DQS read-leveling engine. Sweeps DQSBUFD dynamic
//               delay (and optionally polarity), tracks each lane's longest
//               passing window and centres every lane inside it.
// Revision    : 1.0 - initial release
// ============================================================================
module dqs_rdlvl_ctrl #(
    parameter int LANES     = 2,
    parameter int DLY_W     = 7,
    parameter int SETTLE    = 8,
    parameter int MIN_WIN   = 4,
    parameter int POL_SWEEP = 0,
    parameter int TIMEOUT   = 255
) (
    input  logic                   sclk,
    input  logic                   rst_n,
    input  logic                   cal_start,
    output logic                   cal_busy,
    output logic                   cal_done,
    output logic                   cal_timeout,
    output logic [LANES-1:0]       lane_fail,
    output logic                   rd_req,
    input  logic                   rd_ack,
    input  logic                   rd_vld,
    input  logic [LANES-1:0]       rd_pass,
    output logic [LANES*DLY_W-1:0] dyndelay,
    output logic [LANES-1:0]       dyndelpol
);

    localparam logic [3:0] c_st_idle   = 4'd0;
    localparam logic [3:0] c_st_setdly = 4'd1;
    localparam logic [3:0] c_st_settle = 4'd2;
    localparam logic [3:0] c_st_req    = 4'd3;
    localparam logic [3:0] c_st_wait   = 4'd4;
    localparam logic [3:0] c_st_update = 4'd5;
    localparam logic [3:0] c_st_finish = 4'd6;
    localparam logic [3:0] c_st_done   = 4'd7;
    localparam logic [3:0] c_st_fail   = 4'd8;

    // One counter serves both the settle wait and the read timeout.
    localparam int c_cnt_max = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 2);

    localparam logic [c_cnt_w-1:0] c_settle_last = (SETTLE > 0) ? c_cnt_w'(SETTLE - 1) : '0;
    localparam logic [c_cnt_w-1:0] c_timeout     = c_cnt_w'(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_cnt_one     = c_cnt_w'(1);
    localparam logic [DLY_W-1:0]   c_dly_max     = '1;
    localparam logic [DLY_W:0]     c_min_win     = (DLY_W + 1)'(MIN_WIN);
    localparam logic [DLY_W:0]     c_len_one     = (DLY_W + 1)'(1);

    logic [3:0]         r_state;
    logic [DLY_W-1:0]   r_dly;
    logic               r_pol;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_timeout;
    logic               r_rd_req;
    logic [LANES-1:0]   r_pass;

    logic               w_start;
    logic               w_to_fail;
    logic               w_last;

    assign w_start   = (r_state == c_st_idle) && cal_start;
    assign w_last    = (r_dly == c_dly_max);
    // Timeout counts from the rd_req rise, through the ack phase and the wait for rd_vld.
    assign w_to_fail = (r_cnt >= c_timeout) &&
                       (((r_state == c_st_req) && !rd_ack) ||
                        ((r_state == c_st_wait) && !rd_vld));

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_st_idle;
            r_dly     <= '0;
            r_pol     <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_rd_req  <= 1'b0;
            r_pass    <= '0;
        end else if (w_to_fail) begin
            r_rd_req  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
            r_state   <= c_st_fail;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (cal_start) begin
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_timeout <= 1'b0;
                        r_dly     <= '0;
                        r_pol     <= 1'b0;
                        r_state   <= c_st_setdly;
                    end
                end
                c_st_setdly: begin
                    r_cnt   <= '0;
                    r_state <= c_st_settle;
                end
                c_st_settle: begin
                    if (r_cnt >= c_settle_last) begin
                        r_cnt    <= '0;
                        r_rd_req <= 1'b1;
                        r_state  <= c_st_req;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                c_st_req: begin
                    r_cnt <= r_cnt + c_cnt_one;
                    if (rd_ack) begin
                        r_rd_req <= 1'b0;
                        r_state  <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (rd_vld) begin
                        r_pass  <= rd_pass;
                        r_state <= c_st_update;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                c_st_update: begin
                    if (!w_last) begin
                        r_dly   <= r_dly + 1'b1;
                        r_state <= c_st_setdly;
                    end else if ((POL_SWEEP != 0) && !r_pol) begin
                        r_pol   <= 1'b1;
                        r_dly   <= '0;
                        r_state <= c_st_setdly;
                    end else begin
                        r_state <= c_st_finish;
                    end
                end
                c_st_finish: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= c_st_done;
                end
                c_st_done: r_state <= c_st_idle;
                c_st_fail: r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

    assign cal_busy    = r_busy;
    assign cal_done    = r_done;
    assign cal_timeout = r_timeout;
    assign rd_req      = r_rd_req;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic             r_open;
        logic [DLY_W-1:0] r_run_start;
        logic [DLY_W:0]   r_run_len;
        logic [DLY_W-1:0] r_best_start;
        logic [DLY_W:0]   r_best_len;
        logic             r_best_pol;
        logic [DLY_W-1:0] r_dd;
        logic             r_dp;
        logic             r_fail;

        logic             w_pass;
        logic             w_close;
        logic [DLY_W-1:0] w_ext_start;
        logic [DLY_W:0]   w_ext_len;

        // Run as it stands after this step; it closes on a miss or at the sweep end.
        always_comb begin
            w_pass      = r_pass[i];
            w_close     = (w_pass || r_open) && (!w_pass || w_last);
            w_ext_start = r_run_start;
            w_ext_len   = r_run_len;
            if (w_pass) begin
                if (r_open) begin
                    w_ext_len = r_run_len + c_len_one;
                end else begin
                    w_ext_start = r_dly;
                    w_ext_len   = c_len_one;
                end
            end
        end

        always_ff @(posedge sclk or negedge rst_n) begin
            if (!rst_n) begin
                r_open       <= 1'b0;
                r_run_start  <= '0;
                r_run_len    <= '0;
                r_best_start <= '0;
                r_best_len   <= '0;
                r_best_pol   <= 1'b0;
                r_dd         <= '0;
                r_dp         <= 1'b0;
                r_fail       <= 1'b0;
            end else begin
                if (w_start) begin
                    r_open       <= 1'b0;
                    r_run_start  <= '0;
                    r_run_len    <= '0;
                    r_best_start <= '0;
                    r_best_len   <= '0;
                    r_best_pol   <= 1'b0;
                    r_fail       <= 1'b0;
                end
                if (r_state == c_st_setdly) begin
                    r_dd <= r_dly;
                    r_dp <= r_pol;
                end
                if (r_state == c_st_update) begin
                    r_run_start <= w_ext_start;
                    r_run_len   <= w_ext_len;
                    r_open      <= w_pass && !w_last;
                    // Strictly longer only, so ties keep the earlier window.
                    if (w_close && (w_ext_len > r_best_len)) begin
                        r_best_start <= w_ext_start;
                        r_best_len   <= w_ext_len;
                        r_best_pol   <= r_pol;
                    end
                end
                if (r_state == c_st_finish) begin
                    if (r_best_len >= c_min_win) begin
                        r_dd <= r_best_start + r_best_len[DLY_W:1];
                        r_dp <= r_best_pol;
                    end else begin
                        r_fail <= 1'b1;
                        r_dd   <= '0;
                        r_dp   <= 1'b0;
                    end
                end
                if (w_to_fail) begin
                    r_fail <= 1'b1;
                    r_dd   <= '0;
                    r_dp   <= 1'b0;
                end
            end
        end

        assign dyndelay[i*DLY_W +: DLY_W] = r_dd;
        assign dyndelpol[i]               = r_dp;
        assign lane_fail[i]               = r_fail;
    end

endmodule
`default_nettype wire

// File: tb/tb_dqs_rdlvl_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dqs_rdlvl_ctrl
// Description : Directed bench for dqs_rdlvl_ctrl; a fixed-polarity and a
//               polarity-sweeping instance driven by a pass-window responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dqs_rdlvl_ctrl;

    logic        sclk;
    logic        rst_n;

    logic        a_start, a_busy, a_done, a_tmo, a_req, a_ack, a_vld;
    logic [1:0]  a_fail, a_pass, a_dp;
    logic [13:0] a_dd;

    logic        b_start, b_busy, b_done, b_tmo, b_req, b_ack, b_vld;
    logic [1:0]  b_fail, b_pass, b_dp;
    logic [13:0] b_dd;

    int  n_vec;
    int  n_err;
    bit  a_hold;

    // Pass windows indexed [instance][pol][lane][window]; lo > hi means empty.
    int  lo [2][2][2][2];
    int  hi [2][2][2][2];

    dqs_rdlvl_ctrl u_dut_a (
        .sclk(sclk), .rst_n(rst_n), .cal_start(a_start), .cal_busy(a_busy),
        .cal_done(a_done), .cal_timeout(a_tmo), .lane_fail(a_fail), .rd_req(a_req),
        .rd_ack(a_ack), .rd_vld(a_vld), .rd_pass(a_pass), .dyndelay(a_dd), .dyndelpol(a_dp)
    );

    dqs_rdlvl_ctrl #(.POL_SWEEP(1)) u_dut_b (
        .sclk(sclk), .rst_n(rst_n), .cal_start(b_start), .cal_busy(b_busy),
        .cal_done(b_done), .cal_timeout(b_tmo), .lane_fail(b_fail), .rd_req(b_req),
        .rd_ack(b_ack), .rd_vld(b_vld), .rd_pass(b_pass), .dyndelay(b_dd), .dyndelpol(b_dp)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [1:0] pass_vec(input int ch, input logic [13:0] dd, input logic [1:0] dp);
        logic [1:0] r;
        int d;
        r = '0;
        for (int l = 0; l < 2; l++) begin
            d = int'(dd[l*7 +: 7]);
            for (int w = 0; w < 2; w++)
                if (d >= lo[ch][dp[l]][l][w] && d <= hi[ch][dp[l]][l][w]) r[l] = 1'b1;
        end
        return r;
    endfunction

    task automatic clear_pat();
        for (int c = 0; c < 2; c++)
            for (int p = 0; p < 2; p++)
                for (int l = 0; l < 2; l++)
                    for (int w = 0; w < 2; w++) begin
                        lo[c][p][l][w] = 1;
                        hi[c][p][l][w] = 0;
                    end
    endtask

    task automatic set_win(input int c, input int p, input int l, input int w, input int a, input int b);
        lo[c][p][l][w] = a;
        hi[c][p][l][w] = b;
    endtask

    // Controller models: ack the cycle after rd_req, rd_vld two cycles later; rd_pass is junk otherwise.
    initial begin
        a_ack = 1'b0; a_vld = 1'b0; a_pass = 2'b11;
        forever begin
            @(negedge sclk);
            if (a_req) begin
                a_ack = 1'b1;
                @(negedge sclk);
                a_ack = 1'b0;
                @(negedge sclk);
                if (!(a_hold && a_dd[6:0] == 7'd17)) begin
                    a_vld  = 1'b1;
                    a_pass = pass_vec(0, a_dd, a_dp);
                    @(negedge sclk);
                    a_vld  = 1'b0;
                    a_pass = 2'b11;
                end
            end
        end
    end

    initial begin
        b_ack = 1'b0; b_vld = 1'b0; b_pass = 2'b11;
        forever begin
            @(negedge sclk);
            if (b_req) begin
                b_ack = 1'b1;
                @(negedge sclk);
                b_ack = 1'b0;
                @(negedge sclk);
                b_vld  = 1'b1;
                b_pass = pass_vec(1, b_dd, b_dp);
                @(negedge sclk);
                b_vld  = 1'b0;
                b_pass = 2'b11;
            end
        end
    end

    task automatic run_cal(input int ch);
        int n;
        @(negedge sclk);
        if (ch == 0) a_start = 1'b1; else b_start = 1'b1;
        @(negedge sclk);
        a_start = 1'b0;
        b_start = 1'b0;
        check("busy_after_start", (ch == 0) ? a_busy : b_busy, 1);
        check("done_cleared", (ch == 0) ? a_done : b_done, 0);
        n = 0;
        while (!((ch == 0) ? a_done : b_done) && n < 20000) begin
            @(negedge sclk);
            n++;
        end
        check("done_set", (ch == 0) ? a_done : b_done, 1);
    endtask

    initial begin
        int n;
        n_vec = 0; n_err = 0; a_hold = 1'b0;
        a_start = 1'b0; b_start = 1'b0;
        clear_pat();
        rst_n = 1'b0;
        repeat (3) @(negedge sclk);
        check("rst_a_flags", {a_busy, a_done, a_tmo, a_fail, a_req, a_dp}, 0);
        check("rst_a_dly", a_dd, 0);
        check("rst_b_flags", {b_busy, b_done, b_tmo, b_fail, b_req, b_dp}, 0);
        rst_n = 1'b1;

        // Single windows per lane
        set_win(0, 0, 0, 0, 20, 60);
        set_win(0, 0, 1, 0, 10, 30);
        run_cal(0);
        check("t1_dly", a_dd, {7'd20, 7'd40});
        check("t1_flags", {a_busy, a_tmo, a_fail, a_dp}, 0);
        check("t1_req", a_req, 0);

        // Two windows on lane0, lane1 window still open at the sweep end
        clear_pat();
        set_win(0, 0, 0, 0, 5, 9);
        set_win(0, 0, 0, 1, 50, 69);
        set_win(0, 0, 1, 0, 120, 127);
        run_cal(0);
        check("t2_dly", a_dd, {7'd124, 7'd60});
        check("t2_fail", a_fail, 0);

        // Lane1 window shorter than MIN_WIN
        clear_pat();
        set_win(0, 0, 0, 0, 20, 60);
        set_win(0, 0, 1, 0, 3, 5);
        run_cal(0);
        check("t3_fail", a_fail, 2'b10);
        check("t3_dly", a_dd, {7'd0, 7'd40});

        // Read result withheld at dly=17
        set_win(0, 0, 1, 0, 10, 30);
        a_hold = 1'b1;
        run_cal(0);
        check("t4_timeout", a_tmo, 1);
        check("t4_fail", a_fail, 2'b11);
        check("t4_req_busy", {a_req, a_busy}, 0);
        check("t4_dly", {a_dd, a_dp}, 0);
        a_hold = 1'b0;

        // Asynchronous reset mid-sweep, then a full resweep
        @(negedge sclk);
        a_start = 1'b1;
        @(negedge sclk);
        a_start = 1'b0;
        n = 0;
        while (a_dd[6:0] != 7'd33 && n < 20000) begin
            @(negedge sclk);
            n++;
        end
        check("t5_reach33", a_dd[6:0], 33);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_flags", {a_busy, a_done, a_tmo, a_fail, a_req, a_dp}, 0);
        check("t5_async_dly", a_dd, 0);
        @(negedge sclk);
        rst_n = 1'b1;
        run_cal(0);
        check("t5_resweep_dly", a_dd, {7'd20, 7'd40});
        check("t5_resweep_flags", {a_tmo, a_fail}, 0);

        // Polarity sweep: longer pol1 window wins; full-range lane1 ties -> pol0
        clear_pat();
        set_win(1, 0, 0, 0, 10, 19);
        set_win(1, 1, 0, 0, 40, 69);
        set_win(1, 0, 1, 0, 0, 127);
        set_win(1, 1, 1, 0, 0, 127);
        run_cal(1);
        check("t6_dly", b_dd, {7'd64, 7'd55});
        check("t6_pol", b_dp, 2'b01);
        check("t6_fail", b_fail, 0);

        // Equal-length windows keep pol0; lane1 window exactly MIN_WIN at pol1
        clear_pat();
        set_win(1, 0, 0, 0, 10, 19);
        set_win(1, 1, 0, 0, 40, 49);
        set_win(1, 1, 1, 0, 100, 103);
        run_cal(1);
        check("t7_dly", b_dd, {7'd102, 7'd15});
        check("t7_pol", b_dp, 2'b10);
        check("t7_fail", {b_tmo, b_fail}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
